instr_issue_ctrl: RTL and testbench

- In-order issue controller in front of the 16-bit-instruction ALU processor: 8 registers × 8 bits, ops add/sub/and/or.
- Buffers incoming instructions in a small FIFO and tracks pending destination writes in a per-register scoreboard.
- Issues one instruction per cycle to the processor only when no RAW/WAW hazard exists against in-flight results.
- Sits between the instruction source and the processor's instruction input.

---
 rtl/instr_issue_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_instr_issue_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// instr_issue_ctrl
//
// In-order issue controller placed in front of the 16-bit-instruction ALU
// processor (8 registers x 8 bits). Incoming instructions are buffered in a
// small FIFO. A per-register scoreboard tracks how many cycles remain until
// each pending destination write lands. The head of the queue is issued
// only when it has no RAW hazard on either source and no WAW hazard on its
// destination.
//
// Instruction format: op[15:13] srcA[12:10] srcB[9:7] dst[6:4], [3:0] unused.
//
// Parameters:
//   FIFO_DEPTH  queue entries (power of 2, >= 2)
//   EXEC_LAT    cycles from issue until the destination is written (1..7)
//   CNT_W       width of the saturating hazard-stall counter
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   in_valid    upstream instruction valid
//   in_ready    queue can accept (from registered occupancy only)
//   in_instr    upstream instruction
//   iss_stall   processor hold, blocks new issue
//   iss_valid   one-cycle pulse per issued instruction
//   iss_instr   issued instruction, unmodified; holds when nothing issues
//   fifo_count  current queue occupancy
//   busy        controller state is not IDLE
//   stall_cnt   cycles spent in HAZ, saturating
//
// Optional build macro:
//   ISSUE_FWD_EN  the processor forwards results, so a source only counts as
//                 a hazard while its scoreboard entry is above 1. The WAW
//                 check on the destination is unaffected.
// ---------------------------------------------------------------------------
module instr_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int EXEC_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   in_instr,
    input  logic                          iss_stall,
    output logic                          iss_valid,
    output logic [15:0]                   iss_instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE_C = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);
    localparam logic [2:0]       LAT_C     = 3'(EXEC_LAT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HAZ,
        HOLD
    } state_t;

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [15:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [2:0]       sb_q [8];
    logic [2:0]       sb_d [8];

    logic             iss_valid_q, iss_valid_d;
    logic [15:0]      iss_instr_q, iss_instr_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    state_t           state_q, state_d;

    logic [15:0]      head;
    logic [2:0]       head_src_a;
    logic [2:0]       head_src_b;
    logic [2:0]       head_dst;
    logic             nonempty;
    logic             src_haz;
    logic             haz;
    logic             push;
    logic             issue;
    logic             sb_any;

    // Head decode and hazard detection. With forwarding, a producer whose
    // result lands at the very next edge can feed a source directly, so
    // only entries above 1 still block a read. A destination must always
    // be completely free to keep writes in program order.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        head_src_a = head[12:10];
        head_src_b = head[9:7];
        head_dst   = head[6:4];
        nonempty   = (count_q != '0);
`ifdef ISSUE_FWD_EN
        src_haz    = (sb_q[head_src_a] > 3'd1) | (sb_q[head_src_b] > 3'd1);
`else
        src_haz    = (sb_q[head_src_a] != 3'd0) | (sb_q[head_src_b] != 3'd0);
`endif
        haz        = src_haz | (sb_q[head_dst] != 3'd0);
        // in_ready looks only at the registered count, so a full queue
        // refuses a push even when the head pops in the same cycle.
        in_ready   = (count_q < DEPTH_C);
        push       = in_valid & in_ready;
        issue      = nonempty & ~haz & ~iss_stall;
    end

    // Queue bookkeeping: write at the tail on push, advance the head on
    // issue, and keep occupancy consistent when both happen together.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_instr;
            wr_ptr_d        = wr_ptr_q + PTR_ONE_C;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        end
        case ({push, issue})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Scoreboard: every pending entry counts down once per cycle, and an
    // issue reloads its destination with the full latency, which wins over
    // that register's decrement.
    always_comb begin
        sb_any = 1'b0;
        for (int r = 0; r < 8; r++) begin
            sb_d[r] = (sb_q[r] != 3'd0) ? (sb_q[r] - 3'd1) : 3'd0;
            if (sb_q[r] != 3'd0) begin
                sb_any = 1'b1;
            end
        end
        if (issue) begin
            sb_d[head_dst] = LAT_C;
        end
    end

    // Issue register, controller state and the HAZ-cycle counter. The
    // state is chosen from this cycle's conditions; a processor hold is
    // reported in preference to a hazard.
    always_comb begin
        iss_valid_d = issue;
        iss_instr_d = issue ? head : iss_instr_q;

        state_d = IDLE;
        if (nonempty && iss_stall) begin
            state_d = HOLD;
        end else if (nonempty && haz) begin
            state_d = HAZ;
        end else if (nonempty || sb_any) begin
            state_d = RUN;
        end

        stall_cnt_d = stall_cnt_q;
        if ((state_q == HAZ) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Control and status registers with synchronous reset. Reset drops all
    // queued and in-flight bookkeeping so nothing further issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_instr_q <= '0;
            stall_cnt_q <= '0;
            state_q     <= IDLE;
            for (int r = 0; r < 8; r++) begin
                sb_q[r] <= 3'd0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            iss_instr_q <= iss_instr_d;
            stall_cnt_q <= stall_cnt_d;
            state_q     <= state_d;
            for (int r = 0; r < 8; r++) begin
                sb_q[r] <= sb_d[r];
            end
        end
    end

    // Queue storage holds data only; entries are meaningful solely between
    // the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign iss_valid  = iss_valid_q;
    assign iss_instr  = iss_instr_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE);
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_ctrl
//
// Directed self-checking bench for instr_issue_ctrl with default parameters
// (FIFO_DEPTH=4, EXEC_LAT=2, CNT_W=16). Expected issue edges follow the
// ISSUE_FWD_EN setting the bench is compiled with.
// ---------------------------------------------------------------------------
module tb_instr_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        iss_stall;
    logic        iss_valid;
    logic [15:0] iss_instr;
    logic [2:0]  fifo_count;
    logic        busy;
    logic [15:0] stall_cnt;

    int          checks;
    int          failures;
    int          edge_cnt;
    int          log_edge[$];
    logic [15:0] log_instr[$];

    instr_issue_ctrl #(
        .FIFO_DEPTH(4),
        .EXEC_LAT  (2),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .iss_stall (iss_stall),
        .iss_valid (iss_valid),
        .iss_instr (iss_instr),
        .fifo_count(fifo_count),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends even if a loop misbehaves.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic [2:0] d);
        return {op, a, b, d, 4'b0000};
    endfunction

    // Advance one clock edge, settle, and record any issue seen on it.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
        if (iss_valid === 1'b1) begin
            log_edge.push_back(edge_cnt);
            log_instr.push_back(iss_instr);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        iss_stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        log_edge.delete();
        log_instr.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (iss_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_iss_valid: got %b expected 0", iss_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_fifo_count: got %0d expected 0", fifo_count);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    // Two-instruction dependency pair; shared by the RAW and WAW scenarios.
    task automatic run_pair(input string name, input logic [15:0] i1,
                            input logic [15:0] i2, input int exp_gap,
                            input int exp_stalls);
        int push_edge;
        do_reset();
        in_valid = 1'b1;
        in_instr = i1;
        tick();
        push_edge = edge_cnt;
        in_instr  = i2;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (log_edge.size() !== 2) begin
            failures++;
            $display("[TB] FAIL %s_issue_count: got %0d expected 2", name, log_edge.size());
        end else begin
            checks++;
            if (log_edge[0] !== push_edge + 1) begin
                failures++;
                $display("[TB] FAIL %s_first_edge: got %0d expected %0d", name,
                         log_edge[0], push_edge + 1);
            end
            checks++;
            if (log_edge[1] !== push_edge + 1 + exp_gap) begin
                failures++;
                $display("[TB] FAIL %s_second_edge: got %0d expected %0d", name,
                         log_edge[1], push_edge + 1 + exp_gap);
            end
            checks++;
            if (log_instr[0] !== i1 || log_instr[1] !== i2) begin
                failures++;
                $display("[TB] FAIL %s_payload: got %h %h expected %h %h", name,
                         log_instr[0], log_instr[1], i1, i2);
            end
        end
        checks++;
        if (stall_cnt !== 16'(exp_stalls)) begin
            failures++;
            $display("[TB] FAIL %s_stall_cnt: got %0d expected %0d", name, stall_cnt, exp_stalls);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_busy_drained: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_raw();
`ifdef ISSUE_FWD_EN
        run_pair("raw", 16'b000_001_010_010_0000, 16'b001_010_100_100_0000, 2, 1);
`else
        run_pair("raw", 16'b000_001_010_010_0000, 16'b001_010_100_100_0000, 3, 2);
`endif
    endtask

    task automatic test_waw();
        run_pair("waw", 16'b010_101_110_001_0000, 16'b011_111_000_001_0000, 3, 2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] v[4];
        int          first_push;
        v[0] = mk(3'b000, 3'd0, 3'd6, 3'd1);
        v[1] = mk(3'b001, 3'd6, 3'd0, 3'd3);
        v[2] = mk(3'b010, 3'd0, 3'd0, 3'd5);
        v[3] = mk(3'b100, 3'd6, 3'd6, 3'd7);
        do_reset();
        in_valid   = 1'b1;
        first_push = edge_cnt + 1;
        for (int i = 0; i < 4; i++) begin
            in_instr = v[i];
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (log_edge.size() !== 4) begin
            failures++;
            $display("[TB] FAIL b2b_issue_count: got %0d expected 4", log_edge.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_edge[i] !== first_push + 1 + i || log_instr[i] !== v[i]) begin
                    failures++;
                    $display("[TB] FAIL b2b_issue%0d: got edge %0d instr %h expected edge %0d instr %h",
                             i, log_edge[i], log_instr[i], first_push + 1 + i, v[i]);
                end
            end
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL b2b_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_hold();
        logic [15:0] v[5];
        int          release_edge;
        int          accept_edge;
        logic        acc;
        for (int i = 0; i < 5; i++) begin
            v[i] = mk(3'(i), 3'd0, 3'd7, 3'(i + 1));
        end
        do_reset();
        iss_stall = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = v[i];
            tick();
        end
        in_instr = v[4];
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (fifo_count !== 3'd4 || in_ready !== 1'b0 || iss_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL hold_full%0d: got count %0d ready %b valid %b busy %b expected 4 0 0 1",
                         k, fifo_count, in_ready, iss_valid, busy);
            end
        end
        checks++;
        if (log_edge.size() !== 0) begin
            failures++;
            $display("[TB] FAIL hold_no_issue: got %0d issues expected 0", log_edge.size());
        end
        iss_stall    = 1'b0;
        release_edge = edge_cnt;
        accept_edge  = -1;
        for (int k = 0; k < 10 && accept_edge < 0; k++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid    = 1'b0;
                accept_edge = edge_cnt;
            end
        end
        checks++;
        if (accept_edge !== release_edge + 2) begin
            failures++;
            $display("[TB] FAIL hold_fifth_accept: got edge %0d expected %0d",
                     accept_edge, release_edge + 2);
        end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (log_edge.size() !== 5) begin
            failures++;
            $display("[TB] FAIL hold_issue_count: got %0d expected 5", log_edge.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_edge[i] !== release_edge + 1 + i || log_instr[i] !== v[i]) begin
                    failures++;
                    $display("[TB] FAIL hold_drain%0d: got edge %0d instr %h expected edge %0d instr %h",
                             i, log_edge[i], log_instr[i], release_edge + 1 + i, v[i]);
                end
            end
        end
        checks++;
        if (fifo_count !== 3'd0 || iss_instr !== v[4] || iss_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_final: got count %0d instr %h valid %b expected 0 %h 0",
                     fifo_count, iss_instr, iss_valid, v[4]);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v[5];
        logic [15:0] fresh;
        int          push_edge;
        v[0] = mk(3'b000, 3'd0, 3'd0, 3'd2);
        v[1] = mk(3'b001, 3'd2, 3'd0, 3'd4);
        v[2] = mk(3'b010, 3'd4, 3'd0, 3'd5);
        v[3] = mk(3'b011, 3'd5, 3'd0, 3'd6);
        v[4] = mk(3'b100, 3'd6, 3'd0, 3'd3);
        fresh = mk(3'b001, 3'd4, 3'd5, 3'd4);
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_instr = v[i];
            tick();
        end
        in_valid = 1'b0;
`ifndef ISSUE_FWD_EN
        tick();
`endif
        checks++;
        if (fifo_count !== 3'd3 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrst_pre: got count %0d busy %b expected 3 1", fifo_count, busy);
        end
        log_edge.delete();
        log_instr.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (fifo_count !== 3'd0 || iss_valid !== 1'b0 || busy !== 1'b0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midrst_post: got count %0d valid %b busy %b stalls %0d expected 0 0 0 0",
                     fifo_count, iss_valid, busy, stall_cnt);
        end
        in_valid = 1'b1;
        in_instr = fresh;
        tick();
        push_edge = edge_cnt;
        in_valid  = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (log_edge.size() !== 1) begin
            failures++;
            $display("[TB] FAIL midrst_fresh_count: got %0d expected 1", log_edge.size());
        end else begin
            checks++;
            if (log_edge[0] !== push_edge + 1 || log_instr[0] !== fresh) begin
                failures++;
                $display("[TB] FAIL midrst_fresh_issue: got edge %0d instr %h expected edge %0d instr %h",
                         log_edge[0], log_instr[0], push_edge + 1, fresh);
            end
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midrst_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    // Scenario sequence; each task starts from its own reset.
    initial begin
        checks    = 0;
        failures  = 0;
        edge_cnt  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        iss_stall = 1'b0;
        test_reset();
        test_raw();
        test_back_to_back();
        test_hold();
        test_waw();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
